// File: rtl/binario_para_bcd_if.sv
// Handshake and result bundle between a conversion requester and binario_para_bcd.
// The master side requests conversions; the slave side is the converter.
interface binario_para_bcd_if #(
  parameter int WIDTH_IN = 14,
  parameter int DIGITS   = 4
);
  logic                  start;
  logic [WIDTH_IN-1:0]   valor;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, valor,
    input  busy, done, overflow, bcd
  );

  modport slave (
    input  start, valor,
    output busy, done, overflow, bcd
  );
endinterface

// File: rtl/binario_para_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, saturating at 10^DIGITS-1.
// Optional leading-zero blanking for the 7-segment digits: define BINARIO_PARA_BCD_APAGA_ZEROS_EN.
module binario_para_bcd #(
  parameter int WIDTH_IN = 14,
  parameter int DIGITS   = 4
) (
  input  logic              ADC_CLK_10,
  input  logic              clear,
  binario_para_bcd_if.slave bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH_IN + 1);

  function automatic int unsigned max_val_f(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int unsigned MAX_VAL  = max_val_f(DIGITS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH_IN - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  // Add 3 to every nibble that would reach 10 or more after the next doubling.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] >= 4'd5) r[4*k +: 4] = a[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] saturate(input logic ovf, input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    if (ovf) r = {DIGITS{4'h9}};
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] blank_zeros(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    logic             lead;
    r    = a;
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (a[4*k +: 4] == 4'd0)) r[4*k +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  // Saturation wins over blanking so an overflow always reads as all nines.
  function automatic logic [ACC_W-1:0] finalize(input logic ovf, input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
`ifdef BINARIO_PARA_BCD_APAGA_ZEROS_EN
    r = ovf ? saturate(1'b1, a) : blank_zeros(a);
`else
    r = saturate(ovf, a);
`endif
    return r;
  endfunction

  function automatic logic exceeds(input logic [WIDTH_IN-1:0] v);
    return 32'(v) > MAX_VAL;
  endfunction

  estado_t             estado;
  logic [WIDTH_IN-1:0] sr;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pend;
  logic                busy_r;
  logic                done_r;
  logic                ovf_r;
  logic [ACC_W-1:0]    bcd_r;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
  assign bus.bcd      = bcd_r;

  always_ff @(posedge ADC_CLK_10) begin
    if (!clear) begin
      estado   <= OCIOSO;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      bcd_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.start) begin
            sr       <= bus.valor;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= exceeds(bus.valor);
            busy_r   <= 1'b1;
            estado   <= CONVERTE;
          end
        end
        CONVERTE: begin
          // Adjust then shift; bits leaving the accumulator top only matter on overflow.
          {acc, sr} <= {add3(acc), sr} << 1;
          cnt       <= cnt + 1'b1;
          busy_r    <= 1'b1;
          if (cnt == LAST_STEP) estado <= FIM;
        end
        FIM: begin
          bcd_r  <= finalize(ovf_pend, acc);
          ovf_r  <= ovf_pend;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          if (bus.start) begin
            sr       <= bus.valor;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= exceeds(bus.valor);
            estado   <= CONVERTE;
          end else begin
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
